// File: rtl/wishbone_arb_pkg.sv
// Shared types and helpers for the Wishbone classic arbiter and its picker.
package wishbone_arb_pkg;

  // Arbiter states: waiting for a request, bus owned, owner aborted by the watchdog.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  // Width of an index able to address n controllers (at least one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wishbone_classic_arbiter_rr_picker.sv
// Round-robin picker: first requester found searching upward from last+1 with wrap.
module rr_picker
  import wishbone_arb_pkg::*;
#(
  parameter int NUM_CTRL = 4,
  parameter int IW       = idx_width(NUM_CTRL)
) (
  input  logic [NUM_CTRL-1:0] req,
  input  logic [IW-1:0]       last,
  output logic [NUM_CTRL-1:0] gnt,
  output logic [IW-1:0]       idx,
  output logic                valid
);

  // Scan the NUM_CTRL positions after last; the first hit wins.
  always_comb begin
    int k;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    for (int off = 1; off <= NUM_CTRL; off++) begin
      k = (int'(last) + off) % NUM_CTRL;
      if (!valid && req[k]) begin
        valid  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/wishbone_classic_arbiter.sv
// Round-robin Wishbone classic arbiter: one device shared by NUM_CTRL controllers,
// grant held for a whole cyc, terminations routed to the owner, per-transfer watchdog.
module wishbone_classic_arbiter
  import wishbone_arb_pkg::*;
#(
  parameter int NUM_CTRL   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_CTRL-1:0]              ctrl_cyc_i,
  input  logic [NUM_CTRL-1:0]              ctrl_stb_i,
  input  logic [NUM_CTRL-1:0]              ctrl_we_i,
  input  logic [NUM_CTRL*ADDR_WIDTH-1:0]   ctrl_adr_i,
  input  logic [NUM_CTRL*DATA_WIDTH-1:0]   ctrl_dat_i,
  input  logic [NUM_CTRL*DATA_WIDTH/8-1:0] ctrl_sel_i,
  output logic [DATA_WIDTH-1:0]            ctrl_dat_o,
  output logic [NUM_CTRL-1:0]              ctrl_ack_o,
  output logic [NUM_CTRL-1:0]              ctrl_err_o,
  output logic [NUM_CTRL-1:0]              ctrl_rty_o,
  output logic                             dev_cyc_o,
  output logic                             dev_stb_o,
  output logic                             dev_we_o,
  output logic [ADDR_WIDTH-1:0]            dev_adr_o,
  output logic [DATA_WIDTH-1:0]            dev_dat_o,
  output logic [DATA_WIDTH/8-1:0]          dev_sel_o,
  input  logic [DATA_WIDTH-1:0]            dev_dat_i,
  input  logic                             dev_ack_i,
  input  logic                             dev_err_i,
  input  logic                             dev_rty_i,
  output logic [NUM_CTRL-1:0]              grant_o,
  output logic                             timeout_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IW        = idx_width(NUM_CTRL);
  localparam int CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t            state_reg;
  logic [NUM_CTRL-1:0]   grant_reg;
  logic [IW-1:0]         owner_reg;
  logic [IW-1:0]         last_reg;
  logic [CW-1:0]         wd_count_reg;
  logic                  abort_pulse_reg;

  logic [ADDR_WIDTH-1:0] adr_arr [NUM_CTRL];
  logic [DATA_WIDTH-1:0] dat_arr [NUM_CTRL];
  logic [SEL_WIDTH-1:0]  sel_arr [NUM_CTRL];

  logic [NUM_CTRL-1:0]   pick_gnt;
  logic [IW-1:0]         pick_idx;
  logic                  pick_valid;
  logic                  owned, own_cyc, own_stb, term, fwd;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CTRL; gi++) begin : g_unpack
      assign adr_arr[gi] = ctrl_adr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign dat_arr[gi] = ctrl_dat_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign sel_arr[gi] = ctrl_sel_i[gi*SEL_WIDTH +: SEL_WIDTH];
    end
  endgenerate

  rr_picker #(.NUM_CTRL(NUM_CTRL), .IW(IW)) u_picker (
    .req   (ctrl_cyc_i),
    .last  (last_reg),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign owned   = (state_reg == OWNED);
  assign own_cyc = ctrl_cyc_i[owner_reg];
  assign own_stb = ctrl_stb_i[owner_reg];
  assign term    = dev_ack_i | dev_err_i | dev_rty_i;
  // Terminations only reach an owner that is actively strobing, never during reset.
  assign fwd     = owned & own_cyc & own_stb & ~rst_i;

  assign dev_cyc_o  = owned & own_cyc;
  assign dev_stb_o  = owned & own_stb;
  assign dev_we_o   = owned & ctrl_we_i[owner_reg];
  assign dev_adr_o  = adr_arr[owner_reg];
  assign dev_dat_o  = dat_arr[owner_reg];
  assign dev_sel_o  = sel_arr[owner_reg];
  assign ctrl_dat_o = dev_dat_i;

  assign ctrl_ack_o = (fwd & dev_ack_i) ? grant_reg : '0;
  assign ctrl_rty_o = (fwd & dev_rty_i) ? grant_reg : '0;
  assign ctrl_err_o = ((fwd & dev_err_i) | (abort_pulse_reg & ~rst_i)) ? grant_reg : '0;
  assign grant_o    = grant_reg;
  assign timeout_o  = abort_pulse_reg;

  // Arbitration FSM with inline watchdog; a termination on the expiry cycle beats the abort.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      owner_reg       <= '0;
      last_reg        <= IW'(NUM_CTRL - 1);
      wd_count_reg    <= '0;
      abort_pulse_reg <= 1'b0;
    end else begin
      abort_pulse_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          wd_count_reg <= '0;
          if (pick_valid) begin
            grant_reg <= pick_gnt;
            owner_reg <= pick_idx;
            state_reg <= OWNED;
          end
        end
        OWNED: begin
          if (!own_cyc) begin
            last_reg     <= owner_reg;
            grant_reg    <= '0;
            wd_count_reg <= '0;
            state_reg    <= IDLE;
          end else if (!own_stb || term) begin
            wd_count_reg <= '0;
          end else if (TIMEOUT != 0 && wd_count_reg == CW'(TIMEOUT - 1)) begin
            wd_count_reg    <= '0;
            abort_pulse_reg <= 1'b1;
            state_reg       <= ABORT;
          end else begin
            wd_count_reg <= wd_count_reg + 1'b1;
          end
        end
        ABORT: begin
          if (!own_cyc) begin
            last_reg  <= owner_reg;
            grant_reg <= '0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wishbone_classic_arbiter.md
Name: wishbone_classic_arbiter

Overview:
Round-robin arbiter sharing one Wishbone classic device between NUM_CTRL controllers. It grants the bus per cycle (cyc) and holds the grant until the owner drops cyc, so multi-transfer cycles stay locked. It routes terminations (ack/err/rty) only to the owner. A per-transfer watchdog aborts a stalled device and returns err to the controller. It sits between controller modules and the fake/real device stub in formal and simulation benches.

Parameters:
NUM_CTRL, 4, number of controllers; legal range 2..8.
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 32, data width; must be a multiple of 8.
TIMEOUT, 255, number of cycles stb may wait for a termination before abort; 0 disables the watchdog.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_i  in  1  synchronous, active-high reset.
ctrl_cyc_i  in  NUM_CTRL  per-controller cyc.
ctrl_stb_i  in  NUM_CTRL  per-controller stb.
ctrl_we_i  in  NUM_CTRL  per-controller we.
ctrl_adr_i  in  NUM_CTRL*ADDR_WIDTH  packed addresses; controller k occupies slice k.
ctrl_dat_i  in  NUM_CTRL*DATA_WIDTH  packed write data.
ctrl_sel_i  in  NUM_CTRL*DATA_WIDTH/8  packed byte selects.
ctrl_dat_o  out  DATA_WIDTH  read data, broadcast to all controllers.
ctrl_ack_o / ctrl_err_o / ctrl_rty_o  out  NUM_CTRL each  per-controller terminations.
dev_cyc_o, dev_stb_o, dev_we_o  out  1 each  to device.
dev_adr_o  out  ADDR_WIDTH  to device.
dev_dat_o  out  DATA_WIDTH  to device.
dev_sel_o  out  DATA_WIDTH/8  to device.
dev_dat_i  in  DATA_WIDTH  read data from device.
dev_ack_i, dev_err_i, dev_rty_i  in  1 each  device terminations.
grant_o  out  NUM_CTRL  one-hot owner; all zero when idle.
timeout_o  out  1  one-cycle pulse on each watchdog abort.

Behaviour:
- Reset (rst_i high at an edge): state IDLE, grant_o=0, last-owner pointer=NUM_CTRL-1, watchdog=0, timeout_o=0. All dev_* control outputs and ctrl_ack/err/rty are 0 while grant_o=0, including mid-transfer reset; no termination is forwarded during or after reset.
- States:
  - IDLE: if any ctrl_cyc_i is high, register the grant to the first requester searching from (last+1) mod NUM_CTRL upward with wrap, then go to OWNED. Grant latency is 1 cycle: the device sees cyc the cycle after the request is sampled.
  - OWNED: dev_cyc_o = ctrl_cyc_i[g]; dev_stb_o = ctrl_stb_i[g]. dev_we/adr/dat/sel are muxed combinationally from owner g. ctrl_ack/err/rty_o[g] = dev_*_i, gated by ctrl_cyc_i[g] & ctrl_stb_i[g]; non-owners get 0. When ctrl_cyc_i[g] is low: update last:=g, clear grant, go to IDLE. There is always at least one IDLE cycle between owners.
  - ABORT: entered from OWNED when the watchdog expires. dev_cyc_o=dev_stb_o=0. ctrl_err_o[g]=1 in the entry cycle only, and timeout_o pulses in the same cycle. The block stays in ABORT until ctrl_cyc_i[g] is low, then updates last and goes to IDLE. Device terminations arriving in ABORT are discarded.
- Watchdog: the counter clears whenever stb is low or a termination arrives, and increments while ctrl_stb_i[g] is high with no termination. When count==TIMEOUT-1 with no termination that cycle, the block enters ABORT. A termination on the expiry cycle wins: it is forwarded normally and no abort occurs.
- Multiple simultaneous device terminations are forwarded as received; the arbiter does not resolve them.
- Read data passes combinationally: ctrl_dat_o = dev_dat_i.
- A cyc drop with stb still high is legal; the owner is released anyway.

Decomposition:
- Package wishbone_arb_pkg: typedef arb_state_t {IDLE, OWNED, ABORT}; a function that clogs NUM_CTRL to size the index.
- Sub-module rr_picker (NUM_CTRL): combinational; inputs request vector and last index; outputs one-hot grant plus index. It is reused by later schedulers.
- The watchdog counter is inline in the arbiter.

Test Plan:
- After reset, ctrl0 raises cyc+stb; the device acks 2 cycles later -> grant_o=0001 one cycle after the request; ctrl_ack_o=0001 for exactly 1 cycle; ctrl_ack_o[3:1] stay 0.
- All four controllers hold cyc and each drops cyc after one acked transfer -> grants in order 0001, 0010, 0100, 1000, 0001, with one idle cycle between grants.
- ctrl1 performs 3 back-to-back transfers under one cyc while ctrl2 requests -> ctrl2 is granted only after ctrl1's cyc drops; no interleaving occurs.
- TIMEOUT=4 and the device never responds -> dev_cyc_o drops, ctrl_err_o[g] and timeout_o pulse together, and the state stays ABORT until the controller drops cyc.
- TIMEOUT=4 and the device acks exactly on the expiry cycle -> ack is forwarded, no err, no timeout_o.
- rst_i is asserted mid-transfer while ctrl3 is owner -> next cycle grant_o=0 and all terminations are 0; after release the next grant starts searching from ctrl0.
